// File: rtl/pair_seq_gen_pkg.sv
// pair_seq_gen_pkg
// Shared types and constants for the pair_seq_gen stimulus generator:
// FSM state encoding, idle pair values, LFSR constants and step helpers.
// Optional feature macro used by the top: PAIR_SEQ_GEN_REF_MODEL_EN.

package pair_seq_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EQ   = 2'd1,
        S_NE   = 2'd2
    } state_t;

    // Idle pair is unequal so the downstream detector stays in its initial state.
    localparam logic W1_IDLE = 1'b0;
    localparam logic W2_IDLE = 1'b1;

    // x^4 + x^3 + 1, shift-left Fibonacci form: feedback = bit3 ^ bit2.
    localparam logic [3:0] LFSR_ZERO_SEED = 4'b1000;
    localparam logic [3:0] LFSR_TAP_MASK  = 4'b1100;

    function automatic logic [3:0] lfsr_step(input logic [3:0] s);
        return {s[2:0], ^(s & LFSR_TAP_MASK)};
    endfunction

    // The all-zero state would lock the LFSR, so it is swapped for a legal seed.
    function automatic logic [3:0] seed_fix(input logic [3:0] s);
        return (s == 4'd0) ? LFSR_ZERO_SEED : s;
    endfunction

endpackage

// File: rtl/pair_seq_gen_if.sv
// pair_seq_gen_if
// Control/stimulus bundle of pair_seq_gen.
//   master: drives start, run_len, gap_len, reps, seed; observes the rest.
//   slave : the generator; drives w1, w2, ready, busy, done, z_exp, hits.
// Clock and Reset are not part of the bundle.

interface pair_seq_gen_if #(
    parameter int HIT_W = 8
);
    import pair_seq_gen_pkg::*;

    logic             start;
    logic [3:0]       run_len;
    logic [3:0]       gap_len;
    logic [3:0]       reps;
    logic [3:0]       seed;
    logic             w1;
    logic             w2;
    logic             ready;
    logic             busy;
    logic             done;
    logic             z_exp;
    logic [HIT_W-1:0] hits;

    modport master (
        output start, run_len, gap_len, reps, seed,
        input  w1, w2, ready, busy, done, z_exp, hits
    );

    modport slave (
        input  start, run_len, gap_len, reps, seed,
        output w1, w2, ready, busy, done, z_exp, hits
    );

endinterface

// File: rtl/pair_seq_gen_model.sv
// eq_run_model
// Reference model of the equal-run detector. Counts consecutive cycles with
// w1 == w2 and flags (combinationally, Mealy style) every cycle that is the
// DET_RUN-th or later equal cycle of the current run.
// Ports: Clock, Reset (sync, active-high), w1, w2 in; z out.

module eq_run_model #(
    parameter int DET_RUN = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic w1,
    input  logic w2,
    output logic z
);
    localparam int              CW  = $clog2(DET_RUN + 1);
    localparam logic [CW-1:0]   SAT = CW'(DET_RUN - 1);

    // run_q = equal cycles seen before the current one, saturating at DET_RUN-1.
    logic [CW-1:0] run_q;
    logic          eq;

    assign eq = (w1 == w2);

    always_ff @(posedge Clock) begin
        if (Reset || !eq) begin
            run_q <= '0;
        end else if (run_q != SAT) begin
            run_q <= run_q + CW'(1);
        end
    end

    assign z = eq && (run_q == SAT);

endmodule

// File: rtl/pair_seq_gen.sv
// pair_seq_gen
// Stimulus generator for the equal-run detector: R repetitions of L equal
// pairs followed by G unequal pairs, data bit from a 4-bit LFSR.
// Ports: Clock, Reset (sync, active-high), bus (pair_seq_gen_if.slave).
// Macro PAIR_SEQ_GEN_REF_MODEL_EN builds the detector reference model that
// drives z_exp/hits; without it both are tied to 0.
//
// state  | meaning
// S_IDLE | idle pair 0/1, ready for start
// S_EQ   | emitting equal pairs (w2 = w1)
// S_NE   | emitting unequal pairs (w2 = ~w1)

module pair_seq_gen
    import pair_seq_gen_pkg::*;
#(
    parameter int DET_RUN = 4,
    parameter int HIT_W   = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    pair_seq_gen_if.slave bus
);
    state_t     state;
    logic       w1_q, w2_q, ready_q, busy_q, done_q;
    logic [3:0] lfsr, lfsr_nx, seed_eff;
    logic [3:0] phase, rem, len_l, len_g;
    logic       empty;

    assign lfsr_nx  = lfsr_step(lfsr);
    assign seed_eff = seed_fix(bus.seed);
    assign empty    = (bus.reps == 4'd0) || (bus.run_len == 4'd0 && bus.gap_len == 4'd0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= S_IDLE;
            w1_q    <= W1_IDLE;
            w2_q    <= W2_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lfsr    <= LFSR_ZERO_SEED;
            phase   <= 4'd0;
            rem     <= 4'd0;
            len_l   <= 4'd0;
            len_g   <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        len_l <= bus.run_len;
                        len_g <= bus.gap_len;
                        rem   <= bus.reps;
                        lfsr  <= seed_eff;
                        if (empty) begin
                            done_q <= 1'b1;
                        end else begin
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                            w1_q    <= seed_eff[0];
                            if (bus.run_len != 4'd0) begin
                                state <= S_EQ;
                                phase <= bus.run_len - 4'd1;
                                w2_q  <= seed_eff[0];
                            end else begin
                                state <= S_NE;
                                phase <= bus.gap_len - 4'd1;
                                w2_q  <= ~seed_eff[0];
                            end
                        end
                    end
                end
                S_EQ, S_NE: begin
                    lfsr <= lfsr_nx;
                    if (phase != 4'd0) begin
                        phase <= phase - 4'd1;
                        w1_q  <= lfsr_nx[0];
                        w2_q  <= (state == S_EQ) ? lfsr_nx[0] : ~lfsr_nx[0];
                    end else if (state == S_EQ && len_g != 4'd0) begin
                        state <= S_NE;
                        phase <= len_g - 4'd1;
                        w1_q  <= lfsr_nx[0];
                        w2_q  <= ~lfsr_nx[0];
                    end else if (rem > 4'd1) begin
                        // End of one repetition with more to go.
                        rem  <= rem - 4'd1;
                        w1_q <= lfsr_nx[0];
                        if (len_l != 4'd0) begin
                            state <= S_EQ;
                            phase <= len_l - 4'd1;
                            w2_q  <= lfsr_nx[0];
                        end else begin
                            state <= S_NE;
                            phase <= len_g - 4'd1;
                            w2_q  <= ~lfsr_nx[0];
                        end
                    end else begin
                        state   <= S_IDLE;
                        rem     <= 4'd0;
                        w1_q    <= W1_IDLE;
                        w2_q    <= W2_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    w1_q    <= W1_IDLE;
                    w2_q    <= W2_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.w1    = w1_q;
    assign bus.w2    = w2_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

`ifdef PAIR_SEQ_GEN_REF_MODEL_EN
    logic             z_w;
    logic [HIT_W-1:0] hits_q;

    eq_run_model #(
        .DET_RUN (DET_RUN)
    ) u_model (
        .Clock (Clock),
        .Reset (Reset),
        .w1    (w1_q),
        .w2    (w2_q),
        .z     (z_w)
    );

    // Idle pair is unequal, so z_w is 0 whenever the clear-on-start applies.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hits_q <= '0;
        end else if (state == S_IDLE && bus.start) begin
            hits_q <= '0;
        end else if (z_w && hits_q != '1) begin
            hits_q <= hits_q + HIT_W'(1);
        end
    end

    assign bus.z_exp = z_w;
    assign bus.hits  = hits_q;
`else
    assign bus.z_exp = 1'b0;
    assign bus.hits  = '0;
`endif

endmodule

// File: tb/tb_pair_seq_gen.sv
module tb_pair_seq_gen;

    localparam int DET_RUN = 4;
    localparam int HIT_W   = 8;
`ifdef PAIR_SEQ_GEN_REF_MODEL_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Reset;

    pair_seq_gen_if #(.HIT_W(HIT_W)) bus ();

    pair_seq_gen #(
        .DET_RUN (DET_RUN),
        .HIT_W   (HIT_W)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int n_assert = 0;
    int n_fail   = 0;

    logic [1:0] exp_pair[$];
    bit         exp_z[$];
    logic [1:0] trace[$];
    logic [1:0] trace0[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lfsr_next(input int s);
        return ((s << 1) & 15) | (((s >> 3) ^ (s >> 2)) & 1);
    endfunction

    // Expected pattern from the rules: R x (L equal, G unequal) pairs,
    // data bit = low bit of the LFSR, one LFSR step per pattern cycle.
    task automatic build_model(input int L, input int G, input int R, input int S);
        int s, run;
        exp_pair.delete();
        exp_z.delete();
        s = (S == 0) ? 8 : S;
        if (R != 0 && (L + G) != 0) begin
            for (int r = 0; r < R; r++) begin
                for (int i = 0; i < L; i++) begin
                    exp_pair.push_back({s[0], s[0]});
                    s = lfsr_next(s);
                end
                for (int i = 0; i < G; i++) begin
                    exp_pair.push_back({s[0], ~s[0]});
                    s = lfsr_next(s);
                end
            end
        end
        run = 0;
        foreach (exp_pair[i]) begin
            run = (exp_pair[i][1] == exp_pair[i][0]) ? run + 1 : 0;
            exp_z.push_back(REF_EN && run >= DET_RUN);
        end
    endtask

    // Called in a cycle where the DUT should be ready; returns in the done cycle.
    task automatic run_pattern(input int L, input int G, input int R, input int S);
        int hits_exp;
        build_model(L, G, R, S);
        chk($sformatf("ready_before L%0d G%0d R%0d", L, G, R), bus.ready, 1);
        bus.start   = 1'b1;
        bus.run_len = 4'(L);
        bus.gap_len = 4'(G);
        bus.reps    = 4'(R);
        bus.seed    = 4'(S);
        @(posedge Clock); #1;
        bus.start   = 1'b0;
        bus.run_len = 4'($urandom);
        bus.gap_len = 4'($urandom);
        bus.reps    = 4'($urandom);
        bus.seed    = 4'($urandom);
        hits_exp = 0;
        trace.delete();
        for (int i = 0; i < exp_pair.size(); i++) begin
            chk($sformatf("busy c%0d", i), bus.busy, 1);
            chk($sformatf("ready c%0d", i), bus.ready, 0);
            chk($sformatf("done c%0d", i), bus.done, 0);
            chk($sformatf("w1 c%0d", i), bus.w1, exp_pair[i][1]);
            chk($sformatf("w2 c%0d", i), bus.w2, exp_pair[i][0]);
            chk($sformatf("z_exp c%0d", i), bus.z_exp, exp_z[i]);
            chk($sformatf("hits c%0d", i), bus.hits, hits_exp);
            trace.push_back({bus.w1, bus.w2});
            if (exp_z[i]) hits_exp++;
            @(posedge Clock); #1;
        end
        chk("done_pulse", bus.done, 1);
        chk("done_ready", bus.ready, 1);
        chk("done_busy", bus.busy, 0);
        chk("done_w1", bus.w1, 0);
        chk("done_w2", bus.w2, 1);
        chk("done_z", bus.z_exp, 0);
        chk("done_hits", bus.hits, hits_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int L, G, R, S, hits_exp;
        Reset       = 1'b1;
        bus.start   = 1'b0;
        bus.run_len = 4'd0;
        bus.gap_len = 4'd0;
        bus.reps    = 4'd0;
        bus.seed    = 4'd0;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_w1", bus.w1, 0);
        chk("rst_w2", bus.w2, 1);
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_z", bus.z_exp, 0);
        chk("rst_hits", bus.hits, 0);
        Reset = 1'b0;
        @(posedge Clock); #1;
        chk("idle_done", bus.done, 0);

        // Directed patterns, issued back-to-back in the done cycle.
        run_pattern(4, 1, 1, 5);
        run_pattern(3, 2, 3, 11);
        run_pattern(15, 0, 2, 3);
        run_pattern(0, 0, 7, 9);
        run_pattern(6, 2, 0, 9);
        run_pattern(0, 3, 2, 14);

        // seed 0 behaves like seed 8
        @(posedge Clock); #1;
        run_pattern(5, 3, 2, 0);
        trace0 = trace;
        run_pattern(5, 3, 2, 8);
        chk("seed_trace_len", trace.size(), trace0.size());
        foreach (trace[i]) chk($sformatf("seed_trace c%0d", i), trace[i], trace0[i]);

        // Restart ignored while busy, then reset abandons the pattern.
        build_model(8, 4, 2, 9);
        bus.start = 1'b1; bus.run_len = 4'd8; bus.gap_len = 4'd4;
        bus.reps = 4'd2; bus.seed = 4'd9;
        @(posedge Clock); #1;
        bus.start = 1'b0;
        hits_exp = 0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("abort busy c%0d", i), bus.busy, 1);
            chk($sformatf("abort w1 c%0d", i), bus.w1, exp_pair[i][1]);
            chk($sformatf("abort w2 c%0d", i), bus.w2, exp_pair[i][0]);
            chk($sformatf("abort z c%0d", i), bus.z_exp, exp_z[i]);
            chk($sformatf("abort hits c%0d", i), bus.hits, hits_exp);
            if (exp_z[i]) hits_exp++;
            if (i == 2) begin
                bus.start = 1'b1; bus.run_len = 4'd1; bus.gap_len = 4'd1;
                bus.reps = 4'd1; bus.seed = 4'd6;
            end else begin
                bus.start = 1'b0;
            end
            if (i == 4) Reset = 1'b1;
            @(posedge Clock); #1;
        end
        Reset = 1'b0;
        chk("abort_w1", bus.w1, 0);
        chk("abort_w2", bus.w2, 1);
        chk("abort_ready", bus.ready, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_hits", bus.hits, 0);
        chk("abort_done", bus.done, 0);
        for (int i = 0; i < 12; i++) begin
            @(posedge Clock); #1;
            chk($sformatf("abort no_done c%0d", i), bus.done, 0);
            chk($sformatf("abort idle_busy c%0d", i), bus.busy, 0);
        end

        // Randomized patterns, sometimes with idle gaps between them.
        for (int k = 0; k < 10; k++) begin
            L = $urandom_range(7, 0);
            G = $urandom_range(4, 0);
            R = $urandom_range(3, 0);
            S = $urandom_range(15, 0);
            if ($urandom_range(1, 0) == 1) begin
                @(posedge Clock); #1;
                chk($sformatf("gap_done k%0d", k), bus.done, 0);
            end
            run_pattern(L, G, R, S);
        end

        @(posedge Clock); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
